// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the pipelined ALU.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SHIFT = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_ORR   = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    localparam int FLG_NEG  = 3;
    localparam int FLG_POS  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_OVF  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add signed multiplier: one partial product per cycle on operand magnitudes.
module alu_mul_seq #(
    parameter int W = 10
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mplr_q, mplr_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   mag_a, mag_b;
    logic [2*W-1:0] acc_sum;

    assign mag_a = a_i[W-1] ? -a_i : a_i;
    assign mag_b = b_i[W-1] ? -b_i : b_i;

    // The last iteration's sum feeds the product directly so it can be registered upstream on that same edge.
    assign acc_sum   = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = neg_q ? -acc_sum : acc_sum;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = {{W{1'b0}}, mag_a};
            acc_d   = '0;
            mplr_d  = mag_b;
            neg_d   = a_i[W-1] ^ b_i[W-1];
        end else if (busy_q) begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, iterative MUL, optional saturation and sticky overflow.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int W         = 10,
    parameter bit SHR_ARITH = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic [W-1:0] i_arg0,
    input  logic [W-1:0] i_arg1,
    input  logic [2:0]   i_oper,
    input  logic         i_imm,
    input  logic         i_sat,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic [3:0]   o_flag,
    output logic         o_ovf_sticky,
    input  logic         i_clr_sticky
);

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] W_V   = W'(W);

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [3:0]     flag_q, flag_d;
    logic           sticky_q, sticky_d;
    logic           sat_q, sat_d;

    logic           accept, mul_start, mul_done, load;
    logic [W-1:0]   op_a, op_b, sum, diff, shamt;
    logic           a_pos, a_neg, b_pos, b_neg;
    logic [W-1:0]   alu_res;
    logic           alu_ovf, alu_pos;
    logic [2*W-1:0] mul_prod;
    logic           mul_ovf;
    logic [W-1:0]   raw_res, fin_res;
    logic           sel_ovf, sel_pos, sel_sat;

    assign o_ready      = (state_q == ST_IDLE) && (!valid_q || i_ready);
    assign accept       = i_valid && o_ready;
    assign mul_start    = accept && (i_oper == OP_MUL);
    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_flag       = flag_q;
    assign o_ovf_sticky = sticky_q;

    assign op_a  = i_imm ? i_data : i_arg0;
    assign op_b  = i_arg1;
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[W-1] ? -op_b : op_b;
    assign a_neg = op_a[W-1];
    assign a_pos = !op_a[W-1] && (|op_a);
    assign b_neg = op_b[W-1];
    assign b_pos = !op_b[W-1] && (|op_b);

    alu_mul_seq #(.W(W)) u_mul (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .start_i   (mul_start),
        .a_i       (op_a),
        .b_i       (op_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Product fits in W bits only when its top W+1 bits are a pure sign extension.
    assign mul_ovf = !((&mul_prod[2*W-1:W-1]) || !(|mul_prod[2*W-1:W-1]));

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_pos = 1'b0;
        case (i_oper)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_pos && b_pos && sum[W-1]) ||
                          (a_neg && b_neg && !sum[W-1] && (|sum));
                alu_pos = a_pos;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_pos && b_neg && diff[W-1]) ||
                          (a_neg && b_pos && !diff[W-1] && (|diff));
                alu_pos = a_pos;
            end
            OP_SHIFT: begin
                if (op_b == '0) begin
                    alu_res = op_a;
                end else if (!op_b[W-1]) begin
                    alu_res = (shamt >= W_V) ? '0 : (op_a << shamt);
                end else if (shamt >= W_V) begin
                    // The most negative count also lands here: its magnitude is 2^(W-1).
                    alu_res = (SHR_ARITH && op_a[W-1]) ? '1 : '0;
                end else if (SHR_ARITH) begin
                    alu_res = $signed(op_a) >>> shamt;
                end else begin
                    alu_res = op_a >> shamt;
                end
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_ORR:  alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_XNOR: alu_res = ~(op_a ^ op_b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        raw_res = alu_res;
        sel_ovf = alu_ovf;
        sel_pos = alu_pos;
        sel_sat = i_sat;
        if (mul_done) begin
            raw_res = mul_prod[W-1:0];
            sel_ovf = mul_ovf;
            sel_pos = !mul_prod[2*W-1];
            sel_sat = sat_q;
        end
        fin_res = (sel_sat && sel_ovf) ? (sel_pos ? MAX_V : MIN_V) : raw_res;
    end

    assign load = (accept && (i_oper != OP_MUL)) || mul_done;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        flag_d   = flag_q;
        sticky_d = sticky_q;
        sat_d    = sat_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (mul_start) begin
            sat_d = i_sat;
        end
        if (load) begin
            valid_d          = 1'b1;
            result_d         = fin_res;
            flag_d[FLG_NEG]  = fin_res[W-1];
            flag_d[FLG_POS]  = !fin_res[W-1] && (|fin_res);
            flag_d[FLG_ZERO] = !(|fin_res);
            flag_d[FLG_OVF]  = sel_ovf;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
        // A new overflow outranks a simultaneous clear request.
        if (load && sel_ovf) begin
            sticky_d = 1'b1;
        end else if (i_clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            flag_q   <= 4'b0000;
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench: two DUTs (arithmetic and logical right shift) fed identical stimulus, checked against an integer model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W    = 10;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rstN;
    logic         iValid;
    logic [W-1:0] iData, iArg0, iArg1;
    logic [2:0]   iOper;
    logic         iImm, iSat, iClr;
    logic         holdReady, rndBit, randReady;
    logic         iReady;
    logic         readyA, validA, stickyA, readyL, validL, stickyL;
    logic [W-1:0] resA, resL;
    logic [3:0]   flagA, flagL;

    typedef struct {
        int         resA;
        logic [3:0] flgA;
        int         resL;
        logic [3:0] flgL;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   cycle   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge clk) begin
        #1 rndBit = ($urandom_range(0, 3) != 0);
    end
    assign iReady = randReady ? rndBit : holdReady;

    alu_pipe #(.W(W), .SHR_ARITH(1'b1)) u_dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(iValid), .o_ready(readyA),
        .i_data(iData), .i_arg0(iArg0), .i_arg1(iArg1), .i_oper(iOper),
        .i_imm(iImm), .i_sat(iSat), .o_valid(validA), .i_ready(iReady),
        .o_result(resA), .o_flag(flagA), .o_ovf_sticky(stickyA), .i_clr_sticky(iClr)
    );

    alu_pipe #(.W(W), .SHR_ARITH(1'b0)) u_dutL (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(iValid), .o_ready(readyL),
        .i_data(iData), .i_arg0(iArg0), .i_arg1(iArg1), .i_oper(iOper),
        .i_imm(iImm), .i_sat(iSat), .o_valid(validL), .i_ready(iReady),
        .o_result(resL), .o_flag(flagL), .o_ovf_sticky(stickyL), .i_clr_sticky(iClr)
    );

    task automatic checkOutput(input string name, input int act, input int expv);
        nChecks++;
        if (act == expv) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cycle);
    endtask

    function automatic int wrapW(input int x);
        int m;
        m = x % (1 << W);
        if (m < 0) m += (1 << W);
        if (m > MAXV) m -= (1 << W);
        return m;
    endfunction

    // Integer-level reference: true result, wrap, overflow, optional clamp, then flags.
    function automatic void model(input logic [2:0] op, input int a, input int b, input bit sat,
                                  input bit arith, output int r, output logic [3:0] flg);
        int t;
        bit ovf, satPos;
        logic [W-1:0] va, vb, vr;
        ovf = 0; satPos = 0; r = 0; t = 0;
        va = a[W-1:0];
        vb = b[W-1:0];
        vr = '0;
        case (op)
            OP_ADD: begin
                t = a + b; r = wrapW(t);
                ovf = (a > 0 && b > 0 && r < 0) || (a < 0 && b < 0 && r > 0);
                satPos = (a > 0);
            end
            OP_SUB: begin
                t = a - b; r = wrapW(t);
                ovf = (a > 0 && b < 0 && r < 0) || (a < 0 && b > 0 && r > 0);
                satPos = (a > 0);
            end
            OP_SHIFT: begin
                if (b == 0) r = a;
                else if (b > 0) r = (b >= W) ? 0 : wrapW(a * (1 << b));
                else if (-b >= W) r = (arith && a < 0) ? -1 : 0;
                else if (arith) r = a >>> (-b);
                else r = wrapW(int'(va) >> (-b));
            end
            OP_AND:  begin vr = va & vb;    r = wrapW(int'(vr)); end
            OP_ORR:  begin vr = va | vb;    r = wrapW(int'(vr)); end
            OP_XOR:  begin vr = va ^ vb;    r = wrapW(int'(vr)); end
            OP_XNOR: begin vr = ~(va ^ vb); r = wrapW(int'(vr)); end
            default: begin
                t = a * b; r = wrapW(t);
                ovf = (t > MAXV) || (t < MINV);
                satPos = (t > 0);
            end
        endcase
        if (sat && ovf) r = satPos ? MAXV : MINV;
        flg = {r < 0, r > 0, r == 0, ovf};
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input int data, input int arg0, input int arg1,
                                 input bit imm, input bit sat, output int acceptCycle);
        exp_t e;
        int   a;
        bit   done;
        done = 0;
        acceptCycle = -1;
        iOper = op; iData = data[W-1:0]; iArg0 = arg0[W-1:0]; iArg1 = arg1[W-1:0];
        iImm = imm; iSat = sat; iValid = 1'b1;
        a = wrapW(imm ? data : arg0);
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (readyA) begin
                model(op, a, wrapW(arg1), sat, 1'b1, e.resA, e.flgA);
                model(op, a, wrapW(arg1), sat, 1'b0, e.resL, e.flgL);
                expQ.push_back(e);
                @(posedge clk);
                #1;
                acceptCycle = cycle;
                done = 1;
            end
        end
        if (!done) checkOutput("acceptTimeout", 0, 1);
        iValid = 1'b0;
        iData = W'($urandom); iArg0 = W'($urandom); iArg1 = W'($urandom);
        iOper = 3'($urandom); iImm = 1'($urandom); iSat = 1'($urandom);
    endtask

    task automatic waitResult(output int lat, output bit readyLow);
        lat = -1;
        readyLow = 1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            if (validA) lat = n;
            else if (readyA) readyLow = 0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && expQ.size() != 0; n++) @(posedge clk);
        checkOutput("drainLeftover", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstN && validA) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResult", 1, 0);
            end else begin
                checkOutput("resultArith", $signed(resA), expQ[0].resA);
                checkOutput("flagArith", flagA, expQ[0].flgA);
                checkOutput("resultLogic", $signed(resL), expQ[0].resL);
                checkOutput("flagLogic", flagL, expQ[0].flgL);
                checkOutput("validLogic", validL, 1);
                if (iReady) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        int  c1, c2, c3, lat, highs, dn, a0, a1;
        bit  low;
        logic [W-1:0] held;
        rstN = 1'b0; iValid = 1'b0; iData = '0; iArg0 = '0; iArg1 = '0; iOper = '0;
        iImm = 1'b0; iSat = 1'b0; iClr = 1'b0; holdReady = 1'b1; randReady = 1'b0; rndBit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", validA, 0);
        checkOutput("rstResult", resA, 0);
        checkOutput("rstFlag", flagA, 0);
        checkOutput("rstSticky", stickyA, 0);
        checkOutput("rstReady", readyA, 1);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(OP_ADD, 0, 300, 300, 0, 0, c1);
        waitResult(lat, low);
        checkOutput("addLatency", lat, 1);
        drain();
        checkOutput("stickySet", stickyA, 1);
        applyStimulus(OP_ADD, 0, 300, 300, 0, 1, c1);
        drain();
        iClr = 1'b1;
        @(posedge clk);
        #1 iClr = 1'b0;
        checkOutput("stickyClear", stickyA, 0);
        iClr = 1'b1;
        applyStimulus(OP_SUB, 0, -512, 1, 0, 0, c1);
        iClr = 1'b0;
        checkOutput("stickySetWins", stickyA, 1);
        drain();

        applyStimulus(OP_SUB, 7, 99, 7, 1, 0, c1);
        applyStimulus(OP_SHIFT, 0, 5, -1, 0, 0, c1);
        applyStimulus(OP_SHIFT, 0, 1, 12, 0, 0, c1);
        applyStimulus(OP_SHIFT, 0, -8, -2, 0, 0, c1);
        applyStimulus(OP_SHIFT, 0, -8, -12, 0, 0, c1);
        applyStimulus(OP_SHIFT, 0, -300, -512, 0, 0, c1);
        applyStimulus(OP_SHIFT, 0, 3, 9, 0, 0, c1);
        drain();

        applyStimulus(OP_MUL, 0, 20, -25, 0, 0, c1);
        waitResult(lat, low);
        checkOutput("mulLatency", lat, W + 1);
        checkOutput("mulReadyLow", low, 1);
        drain();
        applyStimulus(OP_MUL, 0, 40, 40, 0, 1, c1);
        applyStimulus(OP_MUL, 0, -512, -512, 0, 0, c1);
        applyStimulus(OP_MUL, 0, -512, 1, 0, 1, c1);
        applyStimulus(OP_MUL, 99, 0, -3, 1, 0, c1);
        drain();

        applyStimulus(OP_ADD, 0, 1, 2, 0, 0, c1);
        applyStimulus(OP_ADD, 0, 3, 4, 0, 0, c2);
        applyStimulus(OP_ADD, 0, 5, 6, 0, 0, c3);
        checkOutput("backToBack1", c2 - c1, 1);
        checkOutput("backToBack2", c3 - c2, 1);
        drain();

        holdReady = 1'b0;
        applyStimulus(OP_XOR, 0, 123, -77, 0, 0, c1);
        @(negedge clk);
        held = resA;
        highs = 0;
        fork
            applyStimulus(OP_ADD, 0, 7, 8, 0, 0, c2);
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (readyA) highs++;
                end
                checkOutput("holdStable", resA, held);
                @(posedge clk);
                #1 holdReady = 1'b1;
            end
        join
        checkOutput("holdReadyLow", highs, 0);
        drain();

        applyStimulus(OP_MUL, 0, 40, 40, 0, 0, c1);
        repeat (3) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midMulRstValid", validA, 0);
        checkOutput("midMulRstResult", resA, 0);
        checkOutput("midMulRstFlag", flagA, 0);
        checkOutput("midMulRstSticky", stickyA, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(OP_ADD, 0, 1, 1, 0, 0, c1);
        waitResult(lat, low);
        checkOutput("postRstLatency", lat, 1);
        drain();

        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a0 = wrapW(int'($urandom_range(0, 1023)));
            a1 = ($urandom_range(0, 1) != 0) ? wrapW(int'($urandom_range(0, 1023)))
                                             : int'($urandom_range(0, 24)) - 12;
            dn = wrapW(int'($urandom_range(0, 1023)));
            applyStimulus(3'($urandom_range(0, 7)), dn, a0, a1, 1'($urandom), 1'($urandom), c1);
        end
        randReady = 1'b0;
        holdReady = 1'b1;
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
